store_buffer: RTL and testbench

// Write-side counterpart of the MEM-stage load path. Accepts store ops (SB/SH/SW/SWL/SWR),

---
 rtl/store_buffer.sv | 185 ++++++++++++++++++
 tb/tb_store_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: formats MIPS-style stores into byte-strobed bus writes, queues them,
// and drains them one at a time over a req/addr_ok/data_ok write bus.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [2:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        flush,
  output logic        st_ready,
  output logic        st_ades,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        sb_empty,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e        state_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          data_req_q;
  logic [1:0]    data_size_q;
  logic [31:0]   data_addr_q;
  logic [3:0]    data_wstrb_q;
  logic [31:0]   data_wdata_q;

  logic [31:0] addr_mem  [DEPTH];
  logic [1:0]  size_mem  [DEPTH];
  logic [3:0]  wstrb_mem [DEPTH];
  logic [31:0] wdata_mem [DEPTH];

  logic        full;
  logic        op_legal;
  logic        push;
  logic        pop;
  logic [1:0]  a;
  logic [31:0] ent_addr;
  logic [1:0]  ent_size;
  logic [3:0]  ent_wstrb;
  logic [31:0] ent_wdata;

  assign a    = st_addr[1:0];
  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    ent_addr  = {st_addr[31:2], 2'b00};
    ent_size  = 2'd2;
    ent_wstrb = 4'b1111;
    ent_wdata = st_data;
    op_legal  = 1'b1;
    case (st_op)
      3'b000: begin
        ent_addr  = st_addr;
        ent_size  = 2'd0;
        ent_wstrb = 4'b0001 << a;
        ent_wdata = {4{st_data[7:0]}};
      end
      3'b001: begin
        ent_addr  = st_addr;
        ent_size  = 2'd1;
        ent_wstrb = a[1] ? 4'b1100 : 4'b0011;
        ent_wdata = {2{st_data[15:0]}};
      end
      3'b010: begin
        ent_addr = st_addr;
      end
      3'b011: begin
        case (a)
          2'b00: begin ent_wstrb = 4'b0001; ent_wdata = {24'b0, st_data[31:24]}; end
          2'b01: begin ent_wstrb = 4'b0011; ent_wdata = {16'b0, st_data[31:16]}; end
          2'b10: begin ent_wstrb = 4'b0111; ent_wdata = {8'b0, st_data[31:8]}; end
          default: begin ent_wstrb = 4'b1111; ent_wdata = st_data; end
        endcase
      end
      3'b100: begin
        case (a)
          2'b00: begin ent_wstrb = 4'b1111; ent_wdata = st_data; end
          2'b01: begin ent_wstrb = 4'b1110; ent_wdata = {st_data[23:0], 8'b0}; end
          2'b10: begin ent_wstrb = 4'b1100; ent_wdata = {st_data[15:0], 16'b0}; end
          default: begin ent_wstrb = 4'b1000; ent_wdata = {st_data[7:0], 24'b0}; end
        endcase
      end
      default: op_legal = 1'b0;
    endcase
  end

  assign st_ades = st_valid & (((st_op == 3'b001) & a[0]) |
                               ((st_op == 3'b010) & (a != 2'b00)));
  assign push = st_valid & ~full & ~flush & ~st_ades & op_legal;
  // A completed write leaves the FIFO whether data_ok arrives with or after addr_ok.
  assign pop  = ((state_q == S_REQ) & data_addr_ok & data_data_ok) |
                ((state_q == S_WAIT) & data_data_ok);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= ent_addr;
      size_mem[wr_ptr_q]  <= ent_size;
      wstrb_mem[wr_ptr_q] <= ent_wstrb;
      wdata_mem[wr_ptr_q] <= ent_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_req_q   <= 1'b0;
      data_size_q  <= 2'd0;
      data_addr_q  <= 32'd0;
      data_wstrb_q <= 4'd0;
      data_wdata_q <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q      <= S_REQ;
            data_req_q   <= 1'b1;
            data_size_q  <= size_mem[rd_ptr_q];
            data_addr_q  <= addr_mem[rd_ptr_q];
            data_wstrb_q <= wstrb_mem[rd_ptr_q];
            data_wdata_q <= wdata_mem[rd_ptr_q];
          end
        end
        S_REQ: begin
          if (data_addr_ok) begin
            data_req_q <= 1'b0;
            state_q    <= data_data_ok ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_data_ok) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Low address bits are forced high on both sides so the compare is word-granular.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] rel;
      rel = PW'(i) - rd_ptr_q;
      if (({1'b0, rel} < count_q) && ((addr_mem[i] | 32'h3) == (ld_addr | 32'h3)))
        ld_hit = 1'b1;
    end
  end

  assign st_ready   = ~full;
  assign sb_empty   = (count_q == '0) & (state_q == S_IDLE);
  assign data_req   = data_req_q;
  assign data_wr    = data_req_q;
  assign data_size  = data_size_q;
  assign data_addr  = data_addr_q;
  assign data_wstrb = data_wstrb_q;
  assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic checked against a
// queue-based reference model of the store formatting, FIFO and write handshake.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic [2:0]  st_op = 3'd0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic        flush = 1'b0;
  logic        st_ready, st_ades, ld_hit, sb_empty;
  logic [31:0] ld_addr = 32'd0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr),
    .st_data(st_data), .flush(flush), .st_ready(st_ready), .st_ades(st_ades),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .sb_empty(sb_empty), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  bit   acc;
  bit   waited;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t model_entry(input logic [2:0] op, input logic [31:0] ad,
                                       input logic [31:0] rt);
    ent_t e;
    int   n;
    n = int'(ad[1:0]);
    e.addr = {ad[31:2], 2'b00};
    e.size = 2'd2;
    e.strb = 4'hF;
    e.data = rt;
    case (op)
      3'd0: begin
        e.addr = ad; e.size = 2'd0;
        e.strb = 4'(1 << n);
        e.data = rt[7:0] * 32'h01010101;
      end
      3'd1: begin
        e.addr = ad; e.size = 2'd1;
        e.strb = (n >= 2) ? 4'hC : 4'h3;
        e.data = rt[15:0] * 32'h00010001;
      end
      3'd2: e.addr = ad;
      3'd3: begin
        e.strb = 4'(15 >> (3 - n));
        e.data = rt >> (8 * (3 - n));
      end
      default: begin
        e.strb = 4'(15 << n);
        e.data = rt << (8 * n);
      end
    endcase
    return e;
  endfunction

  function automatic bit exp_ades();
    return st_valid && ((st_op == 3'd1 && st_addr[0]) ||
                        (st_op == 3'd2 && st_addr[1:0] != 2'b00));
  endfunction

  function automatic bit cur_req();
    return q.size() != 0 && !acc && waited;
  endfunction

  function automatic bit exp_hit();
    foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  // Called at a negedge after inputs are driven; checks, then advances the model one edge.
  task automatic step();
    bit   req, push, pop, new_acc, new_waited;
    ent_t pe;
    #1;
    req = cur_req();
    chk("st_ades", st_ades, exp_ades());
    chk("st_ready", st_ready, q.size() < DEPTH);
    chk("sb_empty", sb_empty, q.size() == 0);
    chk("ld_hit", ld_hit, exp_hit());
    chk("data_req", data_req, req);
    chk("data_wr", data_wr, req);
    if (req && q.size() != 0) begin
      chk("bus_addr", data_addr, q[0].addr);
      chk("bus_size", data_size, q[0].size);
      chk("bus_strb", data_wstrb, q[0].strb);
      chk("bus_data", data_wdata, q[0].data);
    end
    push = st_valid && st_op <= 3'd4 && !exp_ades() && !flush && q.size() < DEPTH;
    pop  = (req && data_addr_ok && data_data_ok) || (acc && data_data_ok);
    new_acc = acc;
    if (req && data_addr_ok && !data_data_ok) new_acc = 1'b1;
    else if (acc && data_data_ok) new_acc = 1'b0;
    new_waited = q.size() != 0 && !acc && !pop;
    pe = model_entry(st_op, st_addr, st_data);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      acc = 1'b0;
      waited = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(pe);
      acc = new_acc;
      waited = new_waited;
    end
    @(negedge clk);
  endtask

  task automatic drive_st(input bit v, input logic [2:0] op, input logic [31:0] ad,
                          input logic [31:0] rt);
    st_valid = v; st_op = op; st_addr = ad; st_data = rt;
  endtask

  task automatic drain();
    st_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 200 && (q.size() != 0 || acc); i++) begin
      data_addr_ok = 1'($urandom % 2);
      data_data_ok = (acc || (cur_req() && data_addr_ok)) ? 1'($urandom % 2) : 1'b0;
      step();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    chk("drain_empty", sb_empty, 1'b1);
  endtask

  initial begin
    acc = 1'b0;
    waited = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    chk("rst_req", data_req, 1'b0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_empty", sb_empty, 1'b1);
    rst = 1'b1;

    // SB replicated across lanes, strobe on lane 3
    drive_st(1, 3'd0, 32'h1003, 32'h000000AB);
    step();
    drive_st(0, 3'd0, 0, 0);
    step();
    chk("t1_req", data_req, 1'b1);
    chk("t1_addr", data_addr, 32'h1003);
    chk("t1_size", data_size, 2'd0);
    chk("t1_strb", data_wstrb, 4'b1000);
    chk("t1_data", data_wdata, 32'hABABABAB);
    drain();

    // SWL / SWR pair at byte 1
    drive_st(1, 3'd3, 32'h2001, 32'h11223344);
    step();
    drive_st(1, 3'd4, 32'h2001, 32'h11223344);
    step();
    drive_st(0, 3'd0, 0, 0);
    chk("t2l_addr", data_addr, 32'h2000);
    chk("t2l_strb", data_wstrb, 4'b0011);
    chk("t2l_data", data_wdata, 32'h00001122);
    data_addr_ok = 1'b1; data_data_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk("t2_bubble", data_req, 1'b0);
    step();
    chk("t2r_strb", data_wstrb, 4'b1110);
    chk("t2r_data", data_wdata, 32'h22334400);
    drain();

    // misaligned SH, flushed SW
    drive_st(1, 3'd1, 32'h3001, 32'h5555);
    step();
    drive_st(1, 3'd2, 32'h3000, 32'h66666666);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_st(0, 3'd0, 0, 0);
    step();
    chk("t3_req", data_req, 1'b0);
    chk("t3_empty", sb_empty, 1'b1);

    // fill to full with bus stalled
    data_addr_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_st(1, 3'd2, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i));
      step();
    end
    drive_st(0, 3'd0, 0, 0);
    chk("t4_full", st_ready, 1'b0);
    drain();
    chk("t4_ready", st_ready, 1'b1);

    // load hit on a pending word
    drive_st(1, 3'd2, 32'h4004, 32'h12345678);
    step();
    drive_st(0, 3'd0, 0, 0);
    ld_addr = 32'h4006;
    #1;
    chk("t5_hit", ld_hit, 1'b1);
    drain();
    chk("t5_nohit", ld_hit, 1'b0);

    // reset while a write is in flight
    for (int i = 0; i < 3; i++) begin
      drive_st(1, 3'd2, 32'h500 + 32'(i * 4), 32'(i));
      step();
    end
    drive_st(0, 3'd0, 0, 0);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_req", data_req, 1'b0);
    chk("t6_empty", sb_empty, 1'b1);
    chk("t6_ready", st_ready, 1'b1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      drive_st(1'($urandom % 2), 3'($urandom_range(0, 7)),
               ($urandom % 4 == 0) ? 32'h800 + 32'($urandom % 64) : $urandom, $urandom);
      flush = ($urandom % 8) == 0;
      if (q.size() != 0 && ($urandom % 2))
        ld_addr = q[$urandom % q.size()].addr ^ 32'($urandom % 4);
      else
        ld_addr = $urandom;
      data_addr_ok = 1'($urandom % 2);
      data_data_ok = (acc || (cur_req() && data_addr_ok)) ? 1'($urandom % 2) : 1'b0;
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
